// File: rtl/cart_mem_bridge_if.sv
// CPU-side and cartridge-memory-side signals of cart_mem_bridge.
// The slave modport is the bridge; the master modport is the CPU/memory environment.
interface cart_mem_bridge_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_A_W = 17
);
    logic               cpu_req;
    logic               cpu_rw;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_ack;
    logic               cpu_miss;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [MEM_A_W-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ack, cpu_miss, mem_r_en, mem_w_en, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_miss, mem_r_en, mem_w_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cart_mem_bridge.sv
// Clocked cartridge-window bridge: req/ack handshake with wait states, registered memory strobes.
// Define CART_MAPPER_EN to add the switchable-bank mapper (writes into the window load the bank).
module cart_mem_bridge #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BANK_W      = 3,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_A_W     = ADDR_W + BANK_W - 2
) (
    input logic              clk,
    input logic              reset,
    cart_mem_bridge_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               r_en_q, r_en_d;
    logic               w_en_q, w_en_d;
    logic               ack_q, ack_d;
    logic               miss_q, miss_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [MEM_A_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [MEM_A_W-1:0] map_addr;
    logic               in_win;

    assign in_win = bus.cpu_addr[ADDR_W-1];

`ifdef CART_MAPPER_EN
    logic [BANK_W-1:0] bank_q, bank_d;

    // Upper half of the window is hard-wired to the last bank.
    always_comb begin
        if (bus.cpu_addr[ADDR_W-2]) begin
            map_addr = MEM_A_W'({{BANK_W{1'b1}}, bus.cpu_addr[ADDR_W-3:0]});
        end else begin
            map_addr = MEM_A_W'({bank_q, bus.cpu_addr[ADDR_W-3:0]});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) bank_q <= '0;
        else       bank_q <= bank_d;
    end
`else
    // Inside the window, addr - 2^(ADDR_W-1) is just the low bits.
    assign map_addr = MEM_A_W'(bus.cpu_addr[ADDR_W-2:0]);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_en_d  = r_en_q;
        w_en_d  = w_en_q;
        ack_d   = 1'b0;
        miss_d  = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef CART_MAPPER_EN
        bank_d  = bank_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    if (!in_win) begin
                        state_d = StDone;
                        ack_d   = 1'b1;
                        miss_d  = 1'b1;
                        rdata_d = '0;
`ifdef CART_MAPPER_EN
                    end else if (!bus.cpu_rw) begin
                        bank_d  = bus.cpu_wdata[BANK_W-1:0];
                        state_d = StDone;
                        ack_d   = 1'b1;
`endif
                    end else begin
                        state_d = StAccess;
                        cnt_d   = 4'(WAIT_CYCLES);
                        addr_d  = map_addr;
                        wdata_d = bus.cpu_wdata;
                        r_en_d  = bus.cpu_rw;
                        w_en_d  = !bus.cpu_rw;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    if (r_en_q) rdata_d = bus.mem_rdata;
                    r_en_d  = 1'b0;
                    w_en_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                r_en_d  = 1'b0;
                w_en_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
            ack_q   <= 1'b0;
            miss_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_en_q  <= r_en_d;
            w_en_q  <= w_en_d;
            ack_q   <= ack_d;
            miss_q  <= miss_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_miss  = miss_q;
    assign bus.mem_r_en  = r_en_q;
    assign bus.mem_w_en  = w_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_cart_mem_bridge.sv
// Directed self-checking bench for cart_mem_bridge (flat build by default, mapper build with
// CART_MAPPER_EN defined).
module tb_cart_mem_bridge;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BANK_W  = 3;
    localparam int unsigned WAITS   = 2;
    localparam int unsigned MEM_A_W = ADDR_W + BANK_W - 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    // Observations gathered by run_access
    int                 obs_nr, obs_nw, obs_nack, obs_ack_cyc;
    logic               obs_both;
    logic [MEM_A_W-1:0] obs_addr;
    logic [DATA_W-1:0]  obs_wdata, obs_rdata;
    logic               obs_miss;

    cart_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_A_W(MEM_A_W)) bus ();

    cart_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_W(BANK_W), .WAIT_CYCLES(WAITS), .MEM_A_W(MEM_A_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request, req dropped after the accepting edge; c = 0 is the cycle after the sample edge.
    task automatic run_access(input logic rw, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
        bus.cpu_req = 1'b1; bus.cpu_rw = rw; bus.cpu_addr = addr;
        bus.cpu_wdata = wd; bus.mem_rdata = rd;
        obs_nr = 0; obs_nw = 0; obs_nack = 0; obs_ack_cyc = -1; obs_both = 1'b0;
        obs_addr = '0; obs_wdata = '0; obs_rdata = '0; obs_miss = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            bus.cpu_req = 1'b0;
            if (bus.mem_r_en && bus.mem_w_en) obs_both = 1'b1;
            if ((bus.mem_r_en || bus.mem_w_en) && obs_nr == 0 && obs_nw == 0) begin
                obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata;
            end
            if (bus.mem_r_en) obs_nr++;
            if (bus.mem_w_en) obs_nw++;
            if (bus.cpu_ack) begin
                if (obs_nack == 0) begin
                    obs_ack_cyc = c; obs_rdata = bus.cpu_rdata; obs_miss = bus.cpu_miss;
                end
                obs_nack++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.mem_r_en, bus.mem_w_en} !== 2'b00)
            $display("FAIL reset_strobes: got %b want 00", {bus.mem_r_en, bus.mem_w_en});
        else n_pass++;
        n_checks++;
        if ({bus.cpu_ack, bus.cpu_miss} !== 2'b00)
            $display("FAIL reset_ack_miss: got %b want 00", {bus.cpu_ack, bus.cpu_miss});
        else n_pass++;
        n_checks++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.cpu_rdata !== '0)
            $display("FAIL reset_buses: addr %h wdata %h rdata %h want 0", bus.mem_addr,
                     bus.mem_wdata, bus.cpu_rdata);
        else n_pass++;
    endtask

    task automatic test_flat_read();
        run_access(1'b1, 16'h8123, 8'h00, 8'h5A);
        n_checks++;
        if (obs_nr !== 3 || obs_nw !== 0 || obs_both)
            $display("FAIL read_strobes: r %0d w %0d both %b want r 3 w 0", obs_nr, obs_nw,
                     obs_both);
        else n_pass++;
        n_checks++;
        if (obs_addr !== 17'h00123) $display("FAIL read_addr: got %h want 00123", obs_addr);
        else n_pass++;
        n_checks++;
        if (obs_ack_cyc !== 3 || obs_nack !== 1)
            $display("FAIL read_ack: cycle %0d count %0d want cycle 3 count 1", obs_ack_cyc,
                     obs_nack);
        else n_pass++;
        n_checks++;
        if (obs_rdata !== 8'h5A || obs_miss !== 1'b0)
            $display("FAIL read_data: rdata %h miss %b want 5a 0", obs_rdata, obs_miss);
        else n_pass++;
    endtask

`ifndef CART_MAPPER_EN
    task automatic test_flat_write();
        run_access(1'b0, 16'hFFFF, 8'hC3, 8'h99);
        n_checks++;
        if (obs_nw !== 3 || obs_nr !== 0 || obs_both)
            $display("FAIL write_strobes: r %0d w %0d both %b want r 0 w 3", obs_nr, obs_nw,
                     obs_both);
        else n_pass++;
        n_checks++;
        if (obs_addr !== 17'h07FFF || obs_wdata !== 8'hC3)
            $display("FAIL write_bus: addr %h wdata %h want 07fff c3", obs_addr, obs_wdata);
        else n_pass++;
        n_checks++;
        if (obs_ack_cyc !== 3 || obs_nack !== 1 || obs_miss !== 1'b0)
            $display("FAIL write_ack: cycle %0d count %0d miss %b want 3 1 0", obs_ack_cyc,
                     obs_nack, obs_miss);
        else n_pass++;
    endtask
`else
    task automatic test_mapper();
        run_access(1'b0, 16'h8000, 8'h05, 8'h00);
        n_checks++;
        if (obs_nr !== 0 || obs_nw !== 0 || obs_ack_cyc !== 0 || obs_miss !== 1'b0)
            $display("FAIL bank_write: r %0d w %0d ack %0d miss %b want 0 0 0 0", obs_nr, obs_nw,
                     obs_ack_cyc, obs_miss);
        else n_pass++;
        run_access(1'b1, 16'h8010, 8'h00, 8'h11);
        n_checks++;
        if (obs_addr !== 17'h14010) $display("FAIL bank_read_lo: got %h want 14010", obs_addr);
        else n_pass++;
        run_access(1'b1, 16'hC010, 8'h00, 8'h22);
        n_checks++;
        if (obs_addr !== 17'h1C010 || obs_rdata !== 8'h22)
            $display("FAIL bank_read_hi: addr %h rdata %h want 1c010 22", obs_addr, obs_rdata);
        else n_pass++;
    endtask
`endif

    task automatic test_miss();
        run_access(1'b1, 16'h7FFF, 8'h00, 8'hAA);
        n_checks++;
        if (obs_nr !== 0 || obs_nw !== 0)
            $display("FAIL miss_rd_strobe: r %0d w %0d want 0 0", obs_nr, obs_nw);
        else n_pass++;
        n_checks++;
        if (obs_ack_cyc !== 0 || obs_nack !== 1 || obs_miss !== 1'b1 || obs_rdata !== 8'h00)
            $display("FAIL miss_rd_ack: cycle %0d count %0d miss %b rdata %h want 0 1 1 00",
                     obs_ack_cyc, obs_nack, obs_miss, obs_rdata);
        else n_pass++;
        run_access(1'b0, 16'h0000, 8'h3C, 8'hAA);
        n_checks++;
        if (obs_nr !== 0 || obs_nw !== 0 || obs_ack_cyc !== 0 || obs_miss !== 1'b1)
            $display("FAIL miss_wr: r %0d w %0d ack %0d miss %b want 0 0 0 1", obs_nr, obs_nw,
                     obs_ack_cyc, obs_miss);
        else n_pass++;
    endtask

    // req held high: the IDLE cycle after the ack starts a second access.
    task automatic test_back_to_back();
        int first;
        int second;
        first = -1; second = -1;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8001; bus.mem_rdata = 8'h42;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.cpu_ack) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (second >= 0) bus.cpu_req = 1'b0;
        end
        bus.cpu_req = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        n_checks++;
        if (first !== 3 || second !== 8)
            $display("FAIL back_to_back: acks at %0d,%0d want 3,8", first, second);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acks;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h8123; bus.mem_rdata = 8'h77;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_r_en !== 1'b1) $display("FAIL mid_pre_strobe: got %b want 1", bus.mem_r_en);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.mem_r_en !== 1'b0 || bus.cpu_ack !== 1'b0)
            $display("FAIL mid_reset_strobe: r_en %b ack %b want 0 0", bus.mem_r_en,
                     bus.cpu_ack);
        else n_pass++;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.cpu_ack) acks++;
        end
        n_checks++;
        if (acks !== 0) $display("FAIL mid_no_ack: got %0d acks want 0", acks);
        else n_pass++;
        run_access(1'b1, 16'h8010, 8'h00, 8'h01);
        n_checks++;
        if (obs_addr !== 17'h00010) $display("FAIL mid_bank_zero: got %h want 00010", obs_addr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_flat_read();
`ifndef CART_MAPPER_EN
        test_flat_write();
`else
        test_mapper();
`endif
        test_miss();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
